// File: rtl/alu_pkg.sv
// Opcodes, FSM states and the legality check shared by the alu and its arbiter.
package alu_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester command/response bus; requester fields packed side by side.
interface alu_arbiter_if #(parameter int N_BITS = 8);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*N_BITS-1:0] req_a;
  logic [2*N_BITS-1:0] req_b;
  logic [11:0]         req_op;
  logic [1:0]          resp_valid;
  logic [1:0]          resp_ready;
  logic [N_BITS-1:0]   resp_data;
  logic                resp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational alu: y = d0 <op> d1, zero for unsupported opcodes.
module alu
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] d0,
  input  logic [N_BITS-1:0] d1,
  input  logic [5:0]        op,
  output logic [N_BITS-1:0] y
);
  always_comb begin
    y = '0;
    case (op)
      OP_ADD: y = d0 + d1;
      OP_SUB: y = d0 - d1;
      OP_AND: y = d0 & d1;
      OP_OR:  y = d0 | d1;
      OP_XOR: y = d0 ^ d1;
      OP_NOR: y = ~(d0 | d1);
      // shifts of N_BITS or more naturally saturate to all-sign / all-zero
      OP_SRA: y = N_BITS'($signed(d0) >>> d1);
      OP_SRL: y = d0 >> d1;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters; IDLE -> EXEC -> RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_BITS = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  state_t              state;
  logic                last_grant, grant, gnt_q, any_req;
  logic [N_BITS-1:0]   a_q, b_q, alu_y, data_q;
  logic [5:0]          op_q;
  logic [1:0]          rvld_q;
  logic                err_q;

  alu #(.N_BITS(N_BITS)) u_alu (.d0(a_q), .d1(b_q), .op(op_q), .y(alu_y));

  // Both requesting: the one not served last wins. Otherwise the lone requester.
  always_comb begin
    any_req = |bus.req_valid;
    grant   = (&bus.req_valid) ? ~last_grant : bus.req_valid[1];
  end

  assign bus.req_ready  = (state == IDLE && any_req) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.resp_valid = rvld_q;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rvld_q     <= 2'b00;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt_q <= grant;
          a_q   <= grant ? bus.req_a[2*N_BITS-1:N_BITS] : bus.req_a[N_BITS-1:0];
          b_q   <= grant ? bus.req_b[2*N_BITS-1:N_BITS] : bus.req_b[N_BITS-1:0];
          op_q  <= grant ? bus.req_op[11:6] : bus.req_op[5:0];
          state <= EXEC;
        end
        EXEC: begin
          data_q <= is_legal_op(op_q) ? alu_y : '0;
          err_q  <= ~is_legal_op(op_q);
          rvld_q <= gnt_q ? 2'b10 : 2'b01;
          state  <= RESP;
        end
        RESP: if (bus.resp_ready[gnt_q]) begin
          rvld_q     <= 2'b00;
          last_grant <= gnt_q;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus arbitration/stall/reset sequences.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.N_BITS(8)) bus ();
  alu_arbiter #(.N_BITS(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic       id;
    logic [5:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_valid[id]      = 1'b1;
    bus.req_a[id*8 +: 8]   = a;
    bus.req_b[id*8 +: 8]   = b;
    bus.req_op[id*6 +: 6]  = op;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Single requester, resp_ready held high; checks accept, EXEC gap and result at T+2.
  task automatic run_txn(input logic id, input logic [5:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp_d, input logic exp_e,
                         input string nm);
    bit got = 0;
    @(negedge clk);
    drive(id, op, a, b);
    bus.resp_ready = 2'b11;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (bus.req_ready[id]) got = 1;
      else @(negedge clk);
    end
    chk($sformatf("%s accept", nm), 32'(got), 32'd1);
    if (!got) begin
      bus.req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s exec_valid", nm), 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    chk($sformatf("%s resp_valid", nm), 32'(bus.resp_valid), id ? 32'd2 : 32'd1);
    chk($sformatf("%s data", nm), 32'(bus.resp_data), 32'(exp_d));
    chk($sformatf("%s err", nm), 32'(bus.resp_err), 32'(exp_e));
    @(posedge clk); #1;
  endtask

  // Both requesters valid together; requester 0 must win, then requester 1 next IDLE.
  task automatic pair(input logic [5:0] op0, input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] e0,
                      input logic [5:0] op1, input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] e1,
                      input string nm);
    @(negedge clk);
    drive(1'b0, op0, a0, b0);
    drive(1'b1, op1, a1, b1);
    bus.resp_ready = 2'b11;
    #1 chk($sformatf("%s first_grant", nm), 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s exec_ready", nm), 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    chk($sformatf("%s resp0_valid", nm), 32'(bus.resp_valid), 32'd1);
    chk($sformatf("%s resp0_data", nm), 32'(bus.resp_data), 32'(e0));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s second_grant", nm), 32'(bus.req_ready), 32'd2);
    chk($sformatf("%s idle_valid", nm), 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk($sformatf("%s resp1_valid", nm), 32'(bus.resp_valid), 32'd2);
    chk($sformatf("%s resp1_data", nm), 32'(bus.resp_data), 32'(e1));
    @(posedge clk); #1;
  endtask

  initial begin
    int n, last_cyc;
    logic [1:0] exp_g;

    vecs[0]  = '{1'b0, OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0};
    vecs[1]  = '{1'b1, OP_SUB, 8'h04, 8'h01, 8'h03, 1'b0};
    vecs[2]  = '{1'b0, OP_OR,  8'h04, 8'h03, 8'h07, 1'b0};
    vecs[3]  = '{1'b1, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[4]  = '{1'b0, OP_XOR, 8'h03, 8'h01, 8'h02, 1'b0};
    vecs[5]  = '{1'b1, 6'h3F,  8'h12, 8'h34, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, OP_NOR, 8'hFE, 8'hFE, 8'h01, 1'b0};
    vecs[7]  = '{1'b1, OP_SRA, 8'h8C, 8'h01, 8'hC6, 1'b0};
    vecs[8]  = '{1'b0, OP_SRL, 8'h0C, 8'h01, 8'h06, 1'b0};
    vecs[9]  = '{1'b1, OP_SRA, 8'h80, 8'h09, 8'hFF, 1'b0};
    vecs[10] = '{1'b0, OP_SRL, 8'h80, 8'h08, 8'h00, 1'b0};
    vecs[11] = '{1'b1, OP_ADD, 8'hFF, 8'h02, 8'h01, 1'b0};
    vecs[12] = '{1'b0, OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0};
    vecs[13] = '{1'b1, OP_SRA, 8'h40, 8'h03, 8'h08, 1'b0};

    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 2'b00;
    do_reset();

    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst resp_data", 32'(bus.resp_data), 32'd0);
    chk("rst resp_err", 32'(bus.resp_err), 32'd0);

    run_txn(1'b0, OP_ADD, 8'd1, 8'd1, 8'd2, 1'b0, "t1_add");

    do_reset();
    pair(OP_SUB, 8'd4, 8'd1, 8'd3, OP_OR, 8'd4, 8'd3, 8'd7, "t2_pair");

    // Both continuously valid: grants must alternate 0,1,0,... three cycles apart.
    @(negedge clk);
    drive(1'b0, OP_ADD, 8'd1, 8'd2);
    drive(1'b1, OP_ADD, 8'd3, 8'd4);
    bus.resp_ready = 2'b11;
    n = 0;
    last_cyc = 0;
    exp_g = 2'b01;
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (bus.req_ready != 2'b00) begin
        chk($sformatf("t3 grant%0d", n), 32'(bus.req_ready), 32'(exp_g));
        if (n > 0) chk($sformatf("t3 spacing%0d", n), 32'(cyc - last_cyc), 32'd3);
        exp_g = ~exp_g;
        last_cyc = cyc;
        n++;
      end
    end
    chk("t3 grant_count", 32'(n), 32'd6);
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Response stall: requester 1 waits, its resp_ready must not release requester 0.
    drive(1'b0, OP_XOR, 8'd3, 8'd1);
    bus.resp_ready = 2'b10;
    #1 chk("t4 accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    drive(1'b1, OP_ADD, 8'd5, 8'd5);
    @(negedge clk);
    chk("t4 exec_ready", 32'(bus.req_ready), 32'd0);
    chk("t4 exec_valid", 32'(bus.resp_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4 hold_valid%0d", i), 32'(bus.resp_valid), 32'd1);
      chk($sformatf("t4 hold_data%0d", i), 32'(bus.resp_data), 32'd2);
      chk($sformatf("t4 hold_ready%0d", i), 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 2'b01;
    @(negedge clk);
    chk("t4 release_valid", 32'(bus.resp_valid), 32'd0);
    chk("t4 next_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    bus.resp_ready = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("t4 req1_valid", 32'(bus.resp_valid), 32'd2);
    chk("t4 req1_data", 32'(bus.resp_data), 32'h0A);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_txn(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_e,
              $sformatf("vec%0d", i));

    // Reset while in EXEC: transaction dropped, requester 0 wins next.
    @(negedge clk);
    drive(1'b0, OP_SRA, 8'd12, 8'd1);
    #1 chk("t6 accept", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6 rst_valid", 32'(bus.resp_valid), 32'd0);
    chk("t6 rst_data", 32'(bus.resp_data), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t6 dropped%0d", i), 32'(bus.resp_valid), 32'd0);
    end
    pair(OP_SRL, 8'd12, 8'd1, 8'h06, OP_SRA, 8'h8C, 8'd1, 8'hC6, "t6_pair");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
